// File: rtl/seg7_capture_if.sv
// Bundle between a 7-seg pattern source and the seg7_capture receiver.
// Carries the raw segment bus, the run enable, and the decoded results/status.
// slave = capture block (consumes seg_in/ena); master = source/observer side.
interface seg7_capture_if #(
  parameter int PERIOD_W = 24
);
  logic [7:0]          seg_in;
  logic                ena;
  logic [3:0]          digit;
  logic                dp;
  logic                digit_valid;
  logic                blank;
  logic                unknown;
  logic                new_strobe;
  logic [7:0]          step_count;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;

  modport slave (
    input  seg_in, ena,
    output digit, dp, digit_valid, blank, unknown,
           new_strobe, step_count, period, period_valid
  );

  modport master (
    output seg_in, ena,
    input  digit, dp, digit_valid, blank, unknown,
           new_strobe, step_count, period, period_valid
  );
endinterface

// File: rtl/seg7_capture.sv
// Samples an async 7-seg+dp bus, debounces each new pattern and decodes it to a hex digit with status.
// Latency: outputs update SYNC_STAGES+STABLE_CYCLES edges after the first edge that samples the new value.
// No backpressure: ena=0 freezes FSM/counters (synchronizer keeps sampling) and gates new_strobe low.
// Ports: clk, rst_n (async active-low), bus (slave): seg_in/ena in; digit, dp, digit_valid, blank,
//        unknown, new_strobe, step_count, period, period_valid out.
module seg7_capture #(
  parameter int STABLE_CYCLES = 512,
  parameter int SYNC_STAGES   = 2,
  parameter int PERIOD_W      = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_capture_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Returns {hit, value}; hit=0 for anything that is not one of the 16 glyphs.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'b0;
    case (s)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  // Input synchronizer; stage 0 takes the raw async bus.
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  synced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.seg_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  state_t              state_q, state_d;
  logic [7:0]          cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          acc_q;
  logic                acc_vld_q;   // something has been accepted since reset
  logic                accept;      // changed pattern accepted this cycle

  logic [3:0]          digit_q;
  logic                dp_q, digit_valid_q, blank_q, unknown_q, strobe_q;
  logic [7:0]          step_q;
  logic [PERIOD_W-1:0] per_cnt_q, period_q;
  logic                period_valid_q;
  logic [4:0]          dec;

  assign dec = decode(cand_q[6:0]);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (bus.ena) begin
      case (state_q)
        EMPTY: begin
          state_d = SETTLE;
          cand_d  = synced;
          cnt_d   = '0;
        end
        LOCKED: begin
          if (synced != acc_q) begin
            state_d = SETTLE;
            cand_d  = synced;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          if (synced != cand_q) begin
            cand_d = synced;
            cnt_d  = '0;
          end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            // Final stable cycle: a glitch that returned to the held pattern locks silently.
            state_d = LOCKED;
            cnt_d   = '0;
            accept  = (cand_q != acc_q) || !acc_vld_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = EMPTY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      acc_vld_q      <= 1'b0;
      digit_q        <= '0;
      dp_q           <= 1'b0;
      digit_valid_q  <= 1'b0;
      blank_q        <= 1'b0;
      unknown_q      <= 1'b0;
      strobe_q       <= 1'b0;
      step_q         <= '0;
      per_cnt_q      <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      strobe_q <= accept;
      if (accept) begin
        acc_q         <= cand_q;
        acc_vld_q     <= 1'b1;
        dp_q          <= cand_q[7];
        digit_valid_q <= dec[4];
        blank_q       <= (cand_q[6:0] == 7'h00);
        unknown_q     <= !dec[4] && (cand_q[6:0] != 7'h00);
        step_q        <= step_q + 8'd1;
        if (dec[4]) begin
          digit_q <= dec[3:0];
        end
        // Counter restarts here, so counter+1 at the next accept is the edge distance.
        if (acc_vld_q) begin
          period_q       <= (&per_cnt_q) ? per_cnt_q : per_cnt_q + PERIOD_W'(1);
          period_valid_q <= 1'b1;
        end
        per_cnt_q <= '0;
      end else if (bus.ena && !(&per_cnt_q)) begin
        per_cnt_q <= per_cnt_q + PERIOD_W'(1);
      end
    end
  end

  assign bus.digit        = digit_q;
  assign bus.dp           = dp_q;
  assign bus.digit_valid  = digit_valid_q;
  assign bus.blank        = blank_q;
  assign bus.unknown      = unknown_q;
  assign bus.new_strobe   = strobe_q & bus.ena;
  assign bus.step_count   = step_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a default instance (STABLE_CYCLES=512, PERIOD_W=24)
// and a small instance (STABLE_CYCLES=16, PERIOD_W=8) for period saturation.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_seg7_capture;

  localparam int LAT  = 1 + 2 + 512;  // ticks from drive to strobe visible: E0 + sync + stable
  localparam int LAT8 = 1 + 2 + 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  int   n_strobe;
  int   lat;
  int   strobe_before;

  seg7_capture_if #(.PERIOD_W(24)) bus ();
  seg7_capture_if #(.PERIOD_W(8))  bus8 ();

  seg7_capture #(.STABLE_CYCLES(512), .SYNC_STAGES(2), .PERIOD_W(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seg7_capture #(.STABLE_CYCLES(16), .SYNC_STAGES(2), .PERIOD_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.new_strobe) n_strobe++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts ticks until the main instance strobes; a missing strobe shows up as n = limit.
  task automatic wait_strobe(output int n);
    n = 0;
    while (!bus.new_strobe && n < 2000) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_strobe8(output int n);
    n = 0;
    while (!bus8.new_strobe && n < 2000) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    n_strobe = 0;
    rst_n = 1'b0;
    bus.seg_in  = 8'h3F;
    bus.ena     = 1'b1;
    bus8.seg_in = 8'h00;
    bus8.ena    = 1'b1;
    tick(4);

    // Reset state
    check("rst_digit", bus.digit, 0);
    check("rst_valid", bus.digit_valid, 0);
    check("rst_strobe", bus.new_strobe, 0);
    check("rst_step", bus.step_count, 0);
    check("rst_pvalid", bus.period_valid, 0);

    // First pattern after reset: 0
    rst_n = 1'b1;
    wait_strobe(lat);
    check("t1_lat", lat, LAT);
    check("t1_digit", bus.digit, 0);
    check("t1_valid", bus.digit_valid, 1);
    check("t1_step", bus.step_count, 1);
    check("t1_pvalid", bus.period_valid, 0);
    check("t1_period", bus.period, 0);
    tick(1);
    check("t1_pulse", bus.new_strobe, 0);

    // Second change 10000 ticks after the first -> period 10000
    tick(10000 - LAT - 1);
    bus.seg_in = 8'h06;
    wait_strobe(lat);
    check("t3_lat", lat, LAT);
    check("t3_period", bus.period, 10000);
    check("t3_pvalid", bus.period_valid, 1);
    check("t3_step", bus.step_count, 2);
    check("t3_digit", bus.digit, 1);

    // Glitch to 2 for 100 cycles, back to 1: silent
    tick(5);
    strobe_before = n_strobe;
    bus.seg_in = 8'h5B;
    tick(100);
    bus.seg_in = 8'h06;
    tick(700);
    check("t2_nostrobe", n_strobe - strobe_before, 0);
    check("t2_digit", bus.digit, 1);
    check("t2_step", bus.step_count, 2);
    check("t2_period", bus.period, 10000);

    // Unknown pattern: digit holds at 1
    bus.seg_in = 8'h49;
    wait_strobe(lat);
    check("t4u_lat", lat, LAT);
    check("t4u_unknown", bus.unknown, 1);
    check("t4u_valid", bus.digit_valid, 0);
    check("t4u_blank", bus.blank, 0);
    check("t4u_digit", bus.digit, 1);
    check("t4u_step", bus.step_count, 3);

    // Blank
    tick(5);
    bus.seg_in = 8'h00;
    wait_strobe(lat);
    check("t4b_blank", bus.blank, 1);
    check("t4b_unknown", bus.unknown, 0);
    check("t4b_digit", bus.digit, 1);

    // 0 then 0 with dp: dp-only change is a change
    tick(5);
    bus.seg_in = 8'h3F;
    wait_strobe(lat);
    check("t4z_digit", bus.digit, 0);
    check("t4z_dp", bus.dp, 0);
    tick(5);
    bus.seg_in = 8'hBF;
    wait_strobe(lat);
    check("t4d_lat", lat, LAT);
    check("t4d_dp", bus.dp, 1);
    check("t4d_digit", bus.digit, 0);
    check("t4d_valid", bus.digit_valid, 1);
    check("t4d_step", bus.step_count, 6);

    // ena low for 50 cycles inside the hold delays the strobe by 50
    tick(5);
    bus.seg_in = 8'h4F;
    tick(100);
    bus.ena = 1'b0;
    tick(50);
    bus.ena = 1'b1;
    lat = 150;
    while (!bus.new_strobe && lat < 2000) begin
      tick(1);
      lat++;
    end
    check("t5e_lat", lat, LAT + 50);
    check("t5e_digit", bus.digit, 3);
    check("t5e_step", bus.step_count, 7);

    // Reset at count 300 of SETTLE on 6
    tick(5);
    bus.seg_in = 8'h7D;
    tick(303);
    rst_n = 1'b0;
    #1;
    check("t6_rdigit", bus.digit, 0);
    check("t6_rstep", bus.step_count, 0);
    check("t6_rvalid", bus.digit_valid, 0);
    check("t6_rdp", bus.dp, 0);
    bus.seg_in = 8'h66;
    tick(3);
    rst_n = 1'b1;
    wait_strobe(lat);
    check("t6_lat", lat, LAT);
    check("t6_digit", bus.digit, 4);
    check("t6_step", bus.step_count, 1);
    check("t6_pvalid", bus.period_valid, 0);

    // Small instance: period 200 fits, period 300 saturates at 0xFF
    tick(5);
    bus8.seg_in = 8'h06;
    wait_strobe8(lat);
    check("p8_lat", lat, LAT8);
    check("p8_digit", bus8.digit, 1);
    tick(200 - LAT8);
    bus8.seg_in = 8'h5B;
    wait_strobe8(lat);
    check("p8_period200", bus8.period, 200);
    check("p8_pvalid", bus8.period_valid, 1);
    tick(300 - LAT8);
    bus8.seg_in = 8'h4F;
    wait_strobe8(lat);
    check("p8_period_sat", bus8.period, 8'hFF);
    check("p8_digit3", bus8.digit, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
